// File: rtl/ah_snoop_wr_arb_pkg.sv
// Shared types and constants for the snooping write arbiter.
package ah_snoop_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SNOOP,
        RESOLVE,
        WRITE
    } state_t;

    localparam int DW_DEF   = 40;
    localparam int NREQ_DEF = 4;
    localparam int CNT_W    = 16;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ah_snoop_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after last_grant+1.
module ah_rr_pick
    import ah_snoop_wr_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   grant,
    output logic            any_valid
);

    always_comb begin
        // NOTE: give every output a default first so no latch is inferred.
        grant     = '0;
        any_valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any_valid && req[(int'(last_grant) + k) % NREQ]) begin
                grant     = IW'((int'(last_grant) + k) % NREQ);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ah_snoop_wr_arb.sv
// Arbitrates requesters into a FIFO, snooping it first and dropping payloads it already holds.
module ah_snoop_wr_arb
    import ah_snoop_wr_arb_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    req_dup,
    output logic [DW-1:0]      f_wdata,
    output logic               f_wvalid,
    input  logic               f_wready,
    output logic [DW-1:0]      f_sdata,
    output logic               f_svalid,
    input  logic               f_smatch,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   wr_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   pick;
    logic            any_valid;
    logic [DW-1:0]   lat_data;
    logic [DW-1:0]   pick_data;

    ah_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick),
        .any_valid  (any_valid)
    );

    assign pick_data = req_data[int'(pick)*DW +: DW];

    // Acks are combinational: the snoop hit and write ready arrive in the ack cycle itself.
    always_comb begin
        req_ack = '0;
        req_dup = '0;
        if (!rstn) begin
            if (state == RESOLVE && f_smatch) begin
                req_ack[idx] = 1'b1;
                req_dup[idx] = 1'b1;
            end else if (state == WRITE && f_wready) begin
                req_ack[idx] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state      <= IDLE;
            idx        <= '0;
            last_grant <= IW'(NREQ - 1);
            lat_data   <= '0;
            f_svalid   <= 1'b0;
            f_sdata    <= '0;
            f_wvalid   <= 1'b0;
            f_wdata    <= '0;
            drop_cnt   <= '0;
            wr_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        idx      <= pick;
                        lat_data <= pick_data;
                        f_svalid <= 1'b1;
                        f_sdata  <= pick_data;
                        state    <= SNOOP;
                    end
                end
                SNOOP: begin
                    f_svalid <= 1'b0;
                    f_sdata  <= '0;
                    state    <= RESOLVE;
                end
                RESOLVE: begin
                    if (f_smatch) begin
                        drop_cnt   <= sat_inc(drop_cnt);
                        last_grant <= idx;
                        state      <= IDLE;
                    end else begin
                        f_wvalid <= 1'b1;
                        f_wdata  <= lat_data;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (f_wready) begin
                        wr_cnt     <= sat_inc(wr_cnt);
                        last_grant <= idx;
                        f_wvalid   <= 1'b0;
                        f_wdata    <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ah_snoop_wr_arb.sv
// Directed bench for ah_snoop_wr_arb: inputs driven just after posedge, outputs checked at negedge.
module tb_ah_snoop_wr_arb;

    localparam int DW   = 40;
    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    req_dup;
    logic [DW-1:0]      f_wdata;
    logic               f_wvalid;
    logic               f_wready = 1'b0;
    logic [DW-1:0]      f_sdata;
    logic               f_svalid;
    logic               f_smatch = 1'b0;
    logic [15:0]        drop_cnt;
    logic [15:0]        wr_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ah_snoop_wr_arb #(.DW(DW), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .req_dup   (req_dup),
        .f_wdata   (f_wdata),
        .f_wvalid  (f_wvalid),
        .f_wready  (f_wready),
        .f_sdata   (f_sdata),
        .f_svalid  (f_svalid),
        .f_smatch  (f_smatch),
        .drop_cnt  (drop_cnt),
        .wr_cnt    (wr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rstn      = 1'b1;
        req_valid = '0;
        f_smatch  = 1'b0;
        f_wready  = 1'b0;
        tick();
        rstn = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        req_valid = 4'hF;
        req_data  = {40'hD3, 40'hD2, 40'hD1, 40'hD0};
        f_wready  = 1'b1;
        f_smatch  = 1'b1;
        tick();
        @(negedge clk);
        total++; if (req_ack !== 4'b0000) $display("FAIL rst_ack: got %b want 0000", req_ack); else passed++;
        total++; if (req_dup !== 4'b0000) $display("FAIL rst_dup: got %b want 0000", req_dup); else passed++;
        total++; if ({f_wvalid, f_svalid} !== 2'b00) $display("FAIL rst_valids: got %b want 00", {f_wvalid, f_svalid}); else passed++;
        total++; if ({f_wdata, f_sdata} !== 80'h0) $display("FAIL rst_data: got %h want 0", {f_wdata, f_sdata}); else passed++;
        total++; if ({drop_cnt, wr_cnt} !== 32'h0) $display("FAIL rst_cnt: got %h want 0", {drop_cnt, wr_cnt}); else passed++;
        tick();
        rstn      = 1'b0;
        req_valid = '0;
        f_wready  = 1'b0;
        f_smatch  = 1'b0;
        @(negedge clk);
        total++; if ({req_ack, f_svalid, f_wvalid} !== 6'b0) $display("FAIL idle_quiet: got %b want 0", {req_ack, f_svalid, f_wvalid}); else passed++;
    endtask

    task automatic test_write();
        tick();
        req_valid = 4'b0001;
        req_data[0 +: DW] = 40'h11;
        f_smatch = 1'b0;
        f_wready = 1'b1;
        @(negedge clk);
        total++; if ({req_ack, f_svalid} !== 5'b0) $display("FAIL wr_t0: got %b want 0", {req_ack, f_svalid}); else passed++;
        tick();
        req_valid = 4'b0000;
        req_data[0 +: DW] = 40'hEE;
        @(negedge clk);
        total++; if ({f_svalid, f_wvalid} !== 2'b10) $display("FAIL wr_snoop_valid: got %b want 10", {f_svalid, f_wvalid}); else passed++;
        total++; if (f_sdata !== 40'h11) $display("FAIL wr_sdata: got %h want 11", f_sdata); else passed++;
        tick();
        @(negedge clk);
        total++; if ({req_ack, f_svalid, f_wvalid} !== 6'b0) $display("FAIL wr_resolve: got %b want 0", {req_ack, f_svalid, f_wvalid}); else passed++;
        tick();
        @(negedge clk);
        total++; if (f_wvalid !== 1'b1 || f_wdata !== 40'h11) $display("FAIL wr_write: got %b/%h want 1/11", f_wvalid, f_wdata); else passed++;
        total++; if (req_ack !== 4'b0001 || req_dup !== 4'b0000) $display("FAIL wr_ack: got %b/%b want 0001/0000", req_ack, req_dup); else passed++;
        tick();
        @(negedge clk);
        total++; if (wr_cnt !== 16'd1) $display("FAIL wr_cnt: got %0d want 1", wr_cnt); else passed++;
        total++; if ({req_ack, f_wvalid} !== 5'b0) $display("FAIL wr_after: got %b want 0", {req_ack, f_wvalid}); else passed++;
    endtask

    task automatic test_dup();
        req_valid = 4'b0001;
        req_data[0 +: DW] = 40'h22;
        f_smatch = 1'b0;
        tick();
        req_valid = 4'b0000;
        f_smatch  = 1'b1;
        @(negedge clk);
        total++; if (f_svalid !== 1'b1 || f_sdata !== 40'h22) $display("FAIL dup_snoop: got %b/%h want 1/22", f_svalid, f_sdata); else passed++;
        tick();
        @(negedge clk);
        total++; if (req_ack !== 4'b0001 || req_dup !== 4'b0001) $display("FAIL dup_ack: got %b/%b want 0001/0001", req_ack, req_dup); else passed++;
        total++; if (f_wvalid !== 1'b0) $display("FAIL dup_nowrite: got %b want 0", f_wvalid); else passed++;
        tick();
        f_smatch = 1'b0;
        @(negedge clk);
        total++; if (drop_cnt !== 16'd1 || wr_cnt !== 16'd1) $display("FAIL dup_cnt: got %0d/%0d want 1/1", drop_cnt, wr_cnt); else passed++;
        total++; if ({req_ack, f_wvalid, f_svalid} !== 6'b0) $display("FAIL dup_after: got %b want 0", {req_ack, f_wvalid, f_svalid}); else passed++;
    endtask

    task automatic test_round_robin();
        int cnt [NREQ];
        logic [NREQ-1:0] exp_ack;
        logic [DW-1:0]   exp_data;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        do_reset();
        req_valid = 4'hF;
        req_data  = {40'hA3, 40'hA2, 40'hA1, 40'hA0};
        f_smatch  = 1'b0;
        f_wready  = 1'b1;
        for (int g = 0; g < 40; g++) begin
            int  n;
            bit  found;
            n = 0;
            found = 1'b0;
            while (!found && n < 8) begin
                @(negedge clk);
                if (|req_ack) found = 1'b1;
                else begin
                    tick();
                    n++;
                end
            end
            exp_ack  = 4'b0001 << (g % NREQ);
            exp_data = 40'hA0 + DW'(g % NREQ);
            total++;
            if (!found) begin
                $display("FAIL rr_timeout: grant %0d got no ack want %b", g, exp_ack);
            end else if (req_ack !== exp_ack || req_dup !== 4'b0 || f_wdata !== exp_data) begin
                $display("FAIL rr_order: grant %0d got %b/%b/%h want %b/0000/%h", g, req_ack, req_dup, f_wdata, exp_ack, exp_data);
            end else begin
                passed++;
            end
            for (int i = 0; i < NREQ; i++) if (req_ack[i]) cnt[i]++;
            if (found) tick();
        end
        for (int i = 0; i < NREQ; i++) begin
            total++; if (cnt[i] !== 10) $display("FAIL rr_fair: req %0d got %0d grants want 10", i, cnt[i]); else passed++;
        end
    endtask

    task automatic test_stall();
        req_valid = 4'b0010;
        req_data[1*DW +: DW] = 40'h55AA55AA55;
        f_wready = 1'b0;
        tick();
        req_valid = 4'b0000;
        req_data[1*DW +: DW] = 40'h0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (f_wvalid !== 1'b1 || f_wdata !== 40'h55AA55AA55 || req_ack !== 4'b0)
                $display("FAIL stall_hold: cycle %0d got %b/%h/%b want 1/55aa55aa55/0000", k, f_wvalid, f_wdata, req_ack);
            else passed++;
            tick();
        end
        f_wready = 1'b1;
        @(negedge clk);
        total++; if (f_wvalid !== 1'b1 || f_wdata !== 40'h55AA55AA55) $display("FAIL stall_last: got %b/%h want 1/55aa55aa55", f_wvalid, f_wdata); else passed++;
        total++; if (req_ack !== 4'b0010 || req_dup !== 4'b0) $display("FAIL stall_ack: got %b/%b want 0010/0000", req_ack, req_dup); else passed++;
        tick();
        @(negedge clk);
        total++; if (f_wvalid !== 1'b0 || wr_cnt !== 16'd41) $display("FAIL stall_done: got %b/%0d want 0/41", f_wvalid, wr_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  found;
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 40'h77;
        f_wready = 1'b0;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        @(negedge clk);
        total++; if (f_wvalid !== 1'b1) $display("FAIL mid_inwrite: got %b want 1", f_wvalid); else passed++;
        tick();
        rstn     = 1'b1;
        f_wready = 1'b1;
        @(negedge clk);
        total++; if (req_ack !== 4'b0) $display("FAIL mid_noack: got %b want 0000", req_ack); else passed++;
        tick();
        rstn      = 1'b0;
        f_wready  = 1'b1;
        req_valid = 4'hF;
        req_data  = {40'hC3, 40'hC2, 40'hC1, 40'hC0};
        @(negedge clk);
        total++; if (f_wvalid !== 1'b0 || req_ack !== 4'b0 || wr_cnt !== 16'd0) $display("FAIL mid_cleared: got %b/%b/%0d want 0/0000/0", f_wvalid, req_ack, wr_cnt); else passed++;
        n = 0;
        found = 1'b0;
        while (!found && n < 8) begin
            @(negedge clk);
            if (|req_ack) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        total++;
        if (!found) $display("FAIL mid_regrant: got no ack want 0001");
        else if (req_ack !== 4'b0001 || f_wdata !== 40'hC0) $display("FAIL mid_regrant: got %b/%h want 0001/c0", req_ack, f_wdata);
        else passed++;
        if (found) tick();
        req_valid = 4'b0;
    endtask

    task automatic test_saturate();
        int nd;
        int budget;
        do_reset();
        req_valid = 4'b0001;
        req_data[0 +: DW] = 40'h99;
        f_smatch = 1'b1;
        f_wready = 1'b0;
        nd = 0;
        budget = 65537 * 3 + 20;
        while (nd < 65537 && budget > 0) begin
            @(negedge clk);
            if (req_dup[0]) nd++;
            budget--;
            tick();
        end
        total++; if (nd !== 65537) $display("FAIL sat_dups: got %0d want 65537", nd); else passed++;
        req_valid = 4'b0;
        f_smatch  = 1'b0;
        @(negedge clk);
        total++; if (drop_cnt !== 16'hFFFF) $display("FAIL sat_drop: got %h want ffff", drop_cnt); else passed++;
        total++; if (wr_cnt !== 16'h0) $display("FAIL sat_wr: got %h want 0000", wr_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_dup();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
